// File: rtl/mul_arb_pkg.sv
// Shared types and sizing helpers for the multiplier arbiter.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int OP_W  = 8;
    localparam int RES_W = 16;

    // Width of the round-robin pointer / owner index; never narrower than 1 bit.
    function automatic int ptr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod N.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = PW'(j);
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one multi-cycle 8x8 multiplier between N requesters.
// Optional MUL_ARB_TIMEOUT_EN adds a RUN-state watchdog that ends the op with rsp_err=1.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*OP_W-1:0] a_in,
    input  logic [N*OP_W-1:0] b_in,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      rsp_valid,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_err,
    output logic              busy,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic              mul_done,
    input  logic [RES_W-1:0]  mul_result
);

    localparam int PW = ptr_w(N);

    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mul_arbiter: parameter out of range");
    end

    state_e        state, state_nx;
    logic [PW-1:0] ptr, owner, pick_idx;
    logic [N-1:0]  pick_gnt;
    logic          pick_any;
    logic          expired;

    rr_pick #(.N(N), .PW(PW)) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign gnt  = (state == IDLE) ? pick_gnt : '0;
    assign busy = (state != IDLE);

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) rsp_valid[owner] = 1'b1;
    end

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    assign expired = (state == RUN) && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst)                                    tcnt <= '0;
        else if (state_nx == RUN && state != RUN)   tcnt <= '0;
        else if (state == RUN)                      tcnt <= tcnt + 1'b1;
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_any) state_nx = RUN;
            RUN:     if (mul_done || expired) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nx;
            // Level is high only while in RUN, so each op gives exactly one rising edge.
            mul_start <= (state_nx == RUN);
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        mul_a <= a_in[OP_W*pick_idx +: OP_W];
                        mul_b <= b_in[OP_W*pick_idx +: OP_W];
                    end
                end
                RUN: begin
                    if (mul_done) begin
                        rsp_result <= mul_result;
                        rsp_err    <= 1'b0;
                    end else if (expired) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end
                end
                RESP: ptr <= (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter with a behavioural multiplier and a done stub.
module tb_mul_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*8-1:0]  a_in = '0;
    logic [N*8-1:0]  b_in = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_result;
    logic            rsp_err;
    logic            busy;
    logic            mul_start;
    logic [7:0]      mul_a;
    logic [7:0]      mul_b;
    logic            mul_done;
    logic [15:0]     mul_result;

    int errors = 0;
    int checks = 0;

    mul_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    // Multiplier: rising edge of start seen at clock k -> done pulse in cycle k+4.
    logic        start_q, p1, p2, p3, m_done;
    logic [15:0] m_prod;
    always @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0; p1 <= 1'b0; p2 <= 1'b0; p3 <= 1'b0; m_done <= 1'b0;
            m_prod  <= '0;
        end else begin
            start_q <= mul_start;
            p1      <= mul_start & ~start_q;
            p2      <= p1;
            p3      <= p2;
            m_done  <= p3;
            if (mul_start & ~start_q) m_prod <= 16'(mul_a) * 16'(mul_b);
        end
    end

    logic stub_mode = 1'b0;
    logic stub_done = 1'b0;
    assign mul_done   = stub_mode ? stub_done : m_done;
    assign mul_result = stub_mode ? 16'hDEAD : m_prod;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_op(input int port, input logic [7:0] a, input logic [7:0] b);
        a_in[8*port +: 8] = a;
        b_in[8*port +: 8] = b;
        req[port]         = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},        gnt,        0);
        chk({tag, "_rsp_valid"},  rsp_valid,  0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_err"},    rsp_err,    0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_mul_start"},  mul_start,  0);
        chk({tag, "_mul_a"},      mul_a,      0);
        chk({tag, "_mul_b"},      mul_b,      0);
    endtask

    // Called in cycle T (operands driven); returns at the sample point of T+6.
    task automatic run_op(input int port, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] prod, input bit hold);
        logic [N-1:0] oh;
        oh       = '0;
        oh[port] = 1'b1;
        sample();
        chk("gnt", gnt, oh);
        chk("busy_at_gnt", busy, 0);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1 && !hold) req[port] = 1'b0;
            sample();
            if (c == 1) begin
                chk("gnt_in_run", gnt, 0);
                chk("mul_start_rise", mul_start, 1);
                chk("mul_a", mul_a, a);
                chk("mul_b", mul_b, b);
                chk("busy_run", busy, 1);
            end
            if (c <= 5) chk("no_early_rsp", rsp_valid, 0);
            if (c == 6) begin
                chk("rsp_valid", rsp_valid, oh);
                chk("rsp_result", rsp_result, prod);
                chk("rsp_err", rsp_err, 0);
                chk("mul_start_resp", mul_start, 0);
                chk("busy_resp", busy, 1);
            end
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        sample();
        check_all_zero("reset");
        step();
        rst = 1'b0;
        sample();
        chk("idle_gnt", gnt, 0);
        chk("idle_busy", busy, 0);

        // Single op: 12*13 on port 2
        step();
        set_op(2, 8'd12, 8'd13);
        run_op(2, 8'd12, 8'd13, 16'd156, 1'b0);
        step();
        sample();
        chk("after_op_valid", rsp_valid, 0);
        chk("after_op_busy", busy, 0);
        chk("result_hold", rsp_result, 16'd156);

        // Max operands on port 0 (ptr is 3, wraps to 0)
        step();
        set_op(0, 8'hFF, 8'hFF);
        run_op(0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);

        // All four requesting from reset: grants 0,1,2,3,0 every 7 cycles
        step();
        rst = 1'b1;
        set_op(0, 8'd3,   8'd4);
        set_op(1, 8'd10,  8'd11);
        set_op(2, 8'd200, 8'd3);
        set_op(3, 8'd255, 8'd2);
        step();
        rst = 1'b0;
        run_op(0, 8'd3, 8'd4, 16'd12, 1'b1);
        step();
        run_op(1, 8'd10, 8'd11, 16'd110, 1'b1);
        step();
        run_op(2, 8'd200, 8'd3, 16'd600, 1'b1);
        step();
        run_op(3, 8'd255, 8'd2, 16'd510, 1'b1);
        step();
        run_op(0, 8'd3, 8'd4, 16'd12, 1'b1);
        step();
        req = '0;
        sample();
        chk("rr_release_gnt", gnt, 0);
        chk("rr_release_busy", busy, 0);

        // Reset at T+3 of a 5*7 op on port 1 drops it
        step();
        set_op(1, 8'd5, 8'd7);
        sample();
        chk("rst_op_gnt", gnt, 4'b0010);
        step();
        req[1] = 1'b0;
        step();
        step();
        rst = 1'b1;
        sample();
        chk("rst_op_busy_t3", busy, 1);
        step();
        rst = 1'b0;
        sample();
        check_all_zero("midop_reset");
        for (int c = 0; c < 6; c++) begin
            step();
            sample();
            chk("dropped_no_rsp", rsp_valid, 0);
            chk("dropped_idle", busy, 0);
        end
        step();
        set_op(3, 8'd9, 8'd9);
        run_op(3, 8'd9, 8'd9, 16'd81, 1'b0);

        // Stray mul_done in IDLE
        step();
        stub_mode = 1'b1;
        stub_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("stray_done_busy", busy, 0);
            chk("stray_done_rsp", rsp_valid, 0);
            chk("stray_done_result", rsp_result, 16'd81);
            step();
        end
        stub_done = 1'b0;
        stub_mode = 1'b0;

`ifdef MUL_ARB_TIMEOUT_EN
        // Timeout: stub never raises done
        stub_mode = 1'b1;
        set_op(2, 8'd3, 8'd3);
        sample();
        chk("to_gnt", gnt, 4'b0100);
        for (int c = 1; c <= TIMEOUT + 1; c++) begin
            step();
            if (c == 1) req[2] = 1'b0;
            sample();
            if (c == 1) chk("to_mul_start", mul_start, 1);
            if (c == TIMEOUT) chk("to_not_yet", rsp_valid, 0);
            if (c == TIMEOUT + 1) begin
                chk("to_rsp_valid", rsp_valid, 4'b0100);
                chk("to_rsp_err", rsp_err, 1);
                chk("to_rsp_result", rsp_result, 0);
                chk("to_mul_start_drop", mul_start, 0);
            end
        end
        step();
        stub_mode = 1'b0;
        sample();
        chk("to_back_idle", busy, 0);
        step();
        set_op(0, 8'd6, 8'd7);
        run_op(0, 8'd6, 8'd7, 16'd42, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
